// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access path. The control unit and
// the access unit both use them.
//   state_t  : access FSM states
//   size_t   : access width decoded from the Byte/Half controls
//   OP_*     : load/store opcodes shared with the control unit decoder
//   isMisaligned() : alignment rule for a given size and low address bits
package dm_access_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_WR,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    function automatic logic isMisaligned(size_t sz, logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Word-wide data-memory bus with a req/ack handshake.
//   bus_req   : request, held until ack
//   bus_we    : 1 = write cycle
//   bus_addr  : word address
//   bus_wdata : write word
//   bus_rdata : read word, valid with bus_ack
//   bus_ack   : single-cycle completion pulse from the slave
interface dm_access_unit_if #(
    parameter int DM_AW = 10
) ();
    logic             bus_req;
    logic             bus_we;
    logic [DM_AW-1:0] bus_addr;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dm_lane_mux.sv
// Combinational little-endian lane logic for sub-word accesses.
//   size/laneSel : access width and byte address bits [1:0]
//   unsign       : zero-extend (1) or sign-extend (0) the loaded lane
//   word         : word read from memory
//   wdata        : store data; low byte/half is inserted into the lane
//   loadData     : extracted + extended load result (word passes through)
//   mergedWord   : word with the store lane replaced (word store -> wdata)
module dm_lane_mux
    import dm_access_unit_pkg::*;
(
    input  size_t       size,
    input  logic        unsign,
    input  logic [1:0]  laneSel,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane   = word[{laneSel, 3'b000} +: 8];
        halfLane   = word[{laneSel[1], 4'b0000} +: 16];
        loadData   = word;
        mergedWord = word;
        case (size)
            SZ_BYTE: begin
                loadData = {{24{~unsign & byteLane[7]}}, byteLane};
                mergedWord[{laneSel, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                loadData = {{16{~unsign & halfLane[15]}}, halfLane};
                mergedWord[{laneSel[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: mergedWord = wdata;
        endcase
    end
endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access unit between the datapath and the memory bus.
// Runs lb/lbu/lh/lhu/lw/sb/sh/sw as bus transactions, sub-word stores as
// read-modify-write, and stalls the CPU until the access completes.
//   clk, rst          : clock, asynchronous active-high reset
//   mem_rd, mem_wr    : MemRead / MemWrite (write wins if both)
//   byte_op, half_op  : access size (byte wins), else word
//   unsign            : zero-extend sub-word loads
//   addr, wdata       : byte address and store data
//   rdata             : load result, valid with done
//   stall             : hold the pipeline
//   done              : one-cycle completion pulse
//   misalign, bus_err : fault flags, qualified by done
//   bus               : memory bus master port
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int DM_AW   = 10,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        byte_op,
    input  logic        half_op,
    input  logic        unsign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign,
    output logic        bus_err,
    dm_access_unit_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state, stateNxt;
    logic [DM_AW+1:0] addrQ;
    logic [31:0]      wdataQ, rdataQ, mergedQ;
    size_t            sizeQ;
    logic             unsignQ, misQ, errQ;
    logic [CW-1:0]    tmoCnt;

    size_t       reqSize;
    logic        reqFault, newReq, isBus, tmoHit;
    logic [31:0] loadData, mergedWord;
    logic        unusedAddrHi;

    assign unusedAddrHi = ^addr[31:DM_AW+2];

    assign reqSize  = byte_op ? SZ_BYTE : (half_op ? SZ_HALF : SZ_WORD);
    assign reqFault = isMisaligned(reqSize, addr[1:0]);
    assign newReq   = (state == ST_IDLE) && (mem_rd || mem_wr);
    assign isBus    = (state == ST_RD) || (state == ST_RMW_RD) ||
                      (state == ST_RMW_WR) || (state == ST_WR);
    // Last wait cycle without ack: abandon the transfer.
    assign tmoHit   = (TIMEOUT != 0) && !bus.bus_ack && (tmoCnt == CW'(TIMEOUT - 1));

    dm_lane_mux uLaneMux (
        .size       (sizeQ),
        .unsign     (unsignQ),
        .laneSel    (addrQ[1:0]),
        .word       (bus.bus_rdata),
        .wdata      (wdataQ),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_rd || mem_wr) begin
                    if (reqFault)              stateNxt = ST_DONE;
                    else if (!mem_wr)          stateNxt = ST_RD;
                    else if (reqSize == SZ_WORD) stateNxt = ST_WR;
                    else                       stateNxt = ST_RMW_RD;
                end
            end
            ST_RMW_RD: begin
                if (bus.bus_ack)  stateNxt = ST_RMW_WR;
                else if (tmoHit)  stateNxt = ST_DONE;
            end
            ST_RD, ST_RMW_WR, ST_WR: begin
                if (bus.bus_ack || tmoHit) stateNxt = ST_DONE;
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ   <= '0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            mergedQ <= '0;
            sizeQ   <= SZ_WORD;
            unsignQ <= 1'b0;
            misQ    <= 1'b0;
            errQ    <= 1'b0;
            tmoCnt  <= '0;
        end else begin
            if (newReq) begin
                addrQ   <= addr[DM_AW+1:0];
                wdataQ  <= wdata;
                sizeQ   <= reqSize;
                unsignQ <= unsign;
                rdataQ  <= '0;     // stores and faults report zero
                misQ    <= reqFault;
                errQ    <= 1'b0;
                tmoCnt  <= '0;
            end
            if (isBus) begin
                // Cleared on ack so the next bus state starts a fresh count.
                if (bus.bus_ack) begin
                    tmoCnt <= '0;
                end else if (tmoHit) begin
                    tmoCnt <= '0;
                    errQ   <= 1'b1;
                end else begin
                    tmoCnt <= tmoCnt + CW'(1);
                end
                if ((state == ST_RD) && bus.bus_ack)     rdataQ  <= loadData;
                if ((state == ST_RMW_RD) && bus.bus_ack) mergedQ <= mergedWord;
            end
        end
    end

    assign stall    = newReq || isBus;
    assign done     = (state == ST_DONE);
    assign misalign = done && misQ;
    assign bus_err  = done && errQ;
    assign rdata    = rdataQ;

    // Bus outputs derive from state, so an async reset drops them at once.
    assign bus.bus_req   = isBus;
    assign bus.bus_we    = (state == ST_RMW_WR) || (state == ST_WR);
    assign bus.bus_addr  = isBus ? addrQ[DM_AW+1:2] : '0;
    assign bus.bus_wdata = (state == ST_WR)     ? wdataQ  :
                           (state == ST_RMW_WR) ? mergedQ : '0;
endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr, byte_op, half_op, unsign;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, misalign, bus_err;

    dm_access_unit_if #(.DM_AW(10)) bus ();

    dm_access_unit #(.DM_AW(10), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .byte_op(byte_op), .half_op(half_op), .unsign(unsign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .done(done), .misalign(misalign), .bus_err(bus_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Bus slave: decides ack at the falling edge, so the DUT sees it at the
    // next rising edge. ackDelay = number of req cycles without ack.
    logic [31:0] mem [0:1023];
    int  ackDelay = 0;
    bit  ackEnable = 1'b1;
    int  waitCnt = 0;

    always @(negedge clk) begin
        bus.bus_ack = 1'b0;
        if (bus.bus_req && ackEnable) begin
            if (waitCnt == ackDelay) begin
                bus.bus_ack = 1'b1;
                waitCnt = 0;
                if (bus.bus_we) mem[bus.bus_addr] = bus.bus_wdata;
                else            bus.bus_rdata = mem[bus.bus_addr];
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    int nChecks = 0;
    int nPass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] rdata;
        bit  mis, err, got, stable, reqAtDone, doneAfter;
        int  stallC, reqC, weC;
    } res_t;

    task automatic runOp(input bit rd, wr, bt, hf, us, input logic [31:0] a, d, output res_t r);
        bit          seen;
        logic        pWe;
        logic [9:0]  pA;
        logic [31:0] pD;
        r = '{rdata: 0, mis: 0, err: 0, got: 0, stable: 1, reqAtDone: 0,
              doneAfter: 0, stallC: 0, reqC: 0, weC: 0};
        seen = 0; pWe = 0; pA = 0; pD = 0;
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; byte_op = bt; half_op = hf; unsign = us;
        addr = a; wdata = d;
        for (int c = 0; c < 60 && !r.got; c++) begin
            @(negedge clk);
            if (done) begin
                r.got = 1; r.rdata = rdata; r.mis = misalign; r.err = bus_err;
                r.reqAtDone = bus.bus_req;
            end else begin
                if (stall) r.stallC++;
                if (bus.bus_req) begin
                    r.reqC++;
                    if (bus.bus_we) r.weC++;
                    if (!seen || bus.bus_we != pWe) begin
                        seen = 1; pWe = bus.bus_we; pA = bus.bus_addr; pD = bus.bus_wdata;
                    end else if (bus.bus_addr != pA || bus.bus_wdata != pD) begin
                        r.stable = 0;
                    end
                end
            end
            @(posedge clk); #1;
            mem_rd = 0; mem_wr = 0;
        end
        @(negedge clk);
        r.doneAfter = done;
    endtask

    typedef struct {
        string       name;
        bit          rd, wr, bt, hf, us;
        logic [31:0] a, d, expRdata, expMem;
        int          expStall, expReq;
        bit          expMis;
    } vec_t;

    function automatic vec_t mk(string n, bit rd, wr, bt, hf, us, logic [31:0] a, d, er, em,
                                int st, rq, bit ms);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.bt = bt; v.hf = hf; v.us = us;
        v.a = a; v.d = d; v.expRdata = er; v.expMem = em;
        v.expStall = st; v.expReq = rq; v.expMis = ms;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        res_t        r;
        logic [31:0] av;
        bit          hit;

        //                 name       rd wr bt hf us addr   wdata         rdata         mem[word]   st rq mis
        vecs.push_back(mk("lb_101",   1, 0, 1, 0, 0, 'h101, 0,            'hFFFFFFAA, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lbu_101",  1, 0, 1, 0, 1, 'h101, 0,            'h000000AA, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lb_100",   1, 0, 1, 0, 0, 'h100, 0,            'hFFFFFFBB, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lbu_103",  1, 0, 1, 0, 1, 'h103, 0,            'h00000088, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lh_102",   1, 0, 0, 1, 0, 'h102, 0,            'hFFFF8899, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lhu_102",  1, 0, 0, 1, 1, 'h102, 0,            'h00008899, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("lw_100",   1, 0, 0, 0, 0, 'h100, 0,            'h8899AABB, 'h8899AABB, 2, 1, 0));
        vecs.push_back(mk("sb_103",   0, 1, 1, 0, 0, 'h103, 'h12345677,   0,          'h7799AABB, 3, 2, 0));
        vecs.push_back(mk("sh_100",   0, 1, 0, 1, 0, 'h100, 'h0000CDEF,   0,          'h8899CDEF, 3, 2, 0));
        vecs.push_back(mk("sh_102",   0, 1, 0, 1, 0, 'h102, 'h1111ABCD,   0,          'hABCDAABB, 3, 2, 0));
        vecs.push_back(mk("sw_100",   0, 1, 0, 0, 0, 'h100, 'hDEADBEEF,   0,          'hDEADBEEF, 2, 1, 0));
        vecs.push_back(mk("lh_101m",  1, 0, 0, 1, 0, 'h101, 0,            0,          'h8899AABB, 1, 0, 1));
        vecs.push_back(mk("lw_102m",  1, 0, 0, 0, 0, 'h102, 0,            0,          'h8899AABB, 1, 0, 1));
        vecs.push_back(mk("sw_101m",  0, 1, 0, 0, 0, 'h101, 'hFFFFFFFF,   0,          'h8899AABB, 1, 0, 1));
        vecs.push_back(mk("rdwr_sb",  1, 1, 1, 0, 0, 'h100, 'h00000055,   0,          'h8899AA55, 3, 2, 0));
        vecs.push_back(mk("bh_lb",    1, 0, 1, 1, 0, 'h101, 0,            'hFFFFFFAA, 'h8899AABB, 2, 1, 0));

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1; mem_rd = 0; mem_wr = 0; byte_op = 0; half_op = 0; unsign = 0;
        addr = 0; wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst flags", {misalign, bus_err}, 0);
        chk("rst rdata", rdata, 0);
        chk("rst bus_req", bus.bus_req, 0);
        chk("rst bus_out", {bus.bus_we, bus.bus_addr, bus.bus_wdata}, 0);
        rst = 0;

        foreach (vecs[i]) begin
            mem[10'h040] = 32'h8899AABB;
            runOp(vecs[i].rd, vecs[i].wr, vecs[i].bt, vecs[i].hf, vecs[i].us,
                  vecs[i].a, vecs[i].d, r);
            av = vecs[i].a;
            chk({vecs[i].name, " got_done"}, r.got, 1);
            chk({vecs[i].name, " rdata"}, r.rdata, vecs[i].expRdata);
            chk({vecs[i].name, " stall_cycles"}, r.stallC, vecs[i].expStall);
            chk({vecs[i].name, " req_cycles"}, r.reqC, vecs[i].expReq);
            chk({vecs[i].name, " misalign"}, r.mis, vecs[i].expMis);
            chk({vecs[i].name, " bus_err"}, r.err, 0);
            chk({vecs[i].name, " mem"}, mem[av[11:2]], vecs[i].expMem);
            chk({vecs[i].name, " done_width"}, r.doneAfter, 0);
        end

        // sw with ack held off for 3 req cycles: 4 req cycles, stable bus.
        mem[10'h041] = 32'h0;
        ackDelay = 3;
        runOp(0, 1, 0, 0, 0, 'h104, 'hDEADBEEF, r);
        ackDelay = 0;
        chk("sw_wait got_done", r.got, 1);
        chk("sw_wait req_cycles", r.reqC, 4);
        chk("sw_wait stall_cycles", r.stallC, 5);
        chk("sw_wait stable", r.stable, 1);
        chk("sw_wait mem", mem[10'h041], 32'hDEADBEEF);
        chk("sw_wait done_width", r.doneAfter, 0);

        // sb with no ack at all: abort after 16 req cycles, never write.
        mem[10'h040] = 32'h8899AABB;
        ackEnable = 0;
        runOp(0, 1, 1, 0, 0, 'h100, 'h00000011, r);
        ackEnable = 1;
        chk("tmo got_done", r.got, 1);
        chk("tmo req_cycles", r.reqC, 16);
        chk("tmo stall_cycles", r.stallC, 17);
        chk("tmo bus_err", r.err, 1);
        chk("tmo misalign", r.mis, 0);
        chk("tmo rdata", r.rdata, 0);
        chk("tmo we_cycles", r.weC, 0);
        chk("tmo req_at_done", r.reqAtDone, 0);
        chk("tmo mem", mem[10'h040], 32'h8899AABB);

        // Reset asserted while the RMW write is outstanding.
        ackDelay = 5;
        @(posedge clk); #1;
        mem_wr = 1; byte_op = 1; half_op = 0; unsign = 0; addr = 'h102; wdata = 'h000000EE;
        @(posedge clk); #1;
        mem_wr = 0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (bus.bus_req && bus.bus_we) hit = 1;
        end
        chk("rstmid reached_rmw_wr", hit, 1);
        #2 rst = 1;
        #1;
        chk("rstmid bus_req", bus.bus_req, 0);
        chk("rstmid stall", stall, 0);
        chk("rstmid done", done, 0);
        ackDelay = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rstmid idle", {stall, done, bus.bus_req}, 0);
        chk("rstmid mem", mem[10'h040], 32'h8899AABB);
        runOp(1, 0, 0, 0, 0, 'h100, 0, r);
        chk("post_rst lw got_done", r.got, 1);
        chk("post_rst lw rdata", r.rdata, 32'h8899AABB);
        chk("post_rst lw stall_cycles", r.stallC, 2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Data-memory side of the control unit's memory interface. Consumes the decoded MemRead/MemWrite/Byte/Half/unsign controls plus the ALU address and rt data.
- Performs lb/lbu/lh/lhu/lw/sb/sh/sw against a word-wide memory bus with a req/ack handshake.
- Sub-word stores are done as read-modify-write. Loads are returned extracted and extended.
- Stalls the CPU until the access completes; sits between the datapath and the data memory/bus.

Parameters:
- DM_AW, 10, word-address width on the bus (bus_addr = addr[DM_AW+1:2])
- TIMEOUT, 16, max cycles to wait for bus_ack before aborting; 0 = wait forever

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_rd  in  1  MemRead from control unit
- mem_wr  in  1  MemWrite from control unit
- byte_op  in  1  Byte (lb/lbu/sb)
- half_op  in  1  Half (lh/lhu/sh)
- unsign  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rt)
- rdata  out  32  load result, valid when done=1
- stall  out  1  hold PC/pipeline while high
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle pulse with done: alignment fault
- bus_err  out  1  one-cycle pulse with done: ack timeout
- bus_req  out  1  bus request
- bus_we  out  1  1 = write cycle
- bus_addr  out  DM_AW  word address
- bus_wdata  out  32  write word
- bus_rdata  in  32  read word, sampled when bus_ack=1
- bus_ack  in  1  slave completion, single-cycle pulse

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; timeout counter 0; latched request cleared. Reset mid-transfer drops bus_req immediately; the slave must tolerate an abandoned request.
- States: IDLE, RD (read for load), RMW_RD, RMW_WR, WR (word store), DONE.
- IDLE:
  - mem_rd|mem_wr high -> latch addr, wdata, size, unsign and op; stall=1 combinationally in the same cycle.
  - mem_wr has priority if both are high.
  - Size is byte if byte_op, else half if half_op, else word; byte_op has priority.
- Alignment check at latch time:
  - Faults: half with addr[0]=1; word with addr[1:0]!=0.
  - On fault: go to DONE with misalign=1, rdata=0, no bus cycle.
- Transitions:
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RMW_RD, then RMW_WR.
- Bus handshake:
  - bus_req=1 in every bus state.
  - bus_addr, bus_we and bus_wdata stay constant until the cycle bus_ack=1 is sampled.
  - The next state is entered on the edge where ack is seen.
  - bus_ack outside a bus state is ignored.
- RMW merge (little-endian): byte lane addr[1:0]=k replaces bits 8k+7:8k with wdata[7:0]; half lane addr[1]=h replaces bits 16h+15:16h with wdata[15:0]. The merged word is registered before RMW_WR.
- Load extract: same lane selection, then sign- or zero-extend per unsign; word loads pass through. rdata is registered, valid and stable throughout DONE.
- DONE: exactly one cycle. done=1, stall=0, next state IDLE. mem_rd/mem_wr are ignored in DONE, so the CPU advances one instruction.
- Latency with zero-wait ack (ack in the first req cycle):
  - load / word store: 2 stall cycles + DONE
  - sub-word store: 3 stall cycles + DONE
  - misaligned access: 1 stall cycle + DONE
- Timeout (TIMEOUT>0):
  - Counter resets on entry to each bus state and increments each cycle without ack.
  - When it reaches TIMEOUT: drop bus_req, go to DONE with bus_err=1, rdata=0.
  - An aborted RMW does not write.
- rdata is 0 in DONE for stores.

Decomposition:
- Shared package:
  - state encoding
  - size encoding: SZ_BYTE, SZ_HALF, SZ_WORD
  - opcode constants for lb/lbu/lh/lhu/lw/sb/sh/sw, shared with the control unit
- One natural sub-module: dm_lane_mux, combinational. Provides byte/half lane extract with sign/zero extension, and lane merge for RMW. Reused by any future cache path.

Test Plan:
- Memory word 0x00000040 = 0x8899AABB, zero-wait ack. lb addr 0x101 -> rdata 0xFFFFFFAA; lbu addr 0x101 -> 0x000000AA; lh addr 0x102 -> 0xFFFF8899. Each: stall 2 cycles, then done.
- sb wdata 0x12345677 to addr 0x103 over 0x8899AABB -> RMW_RD then RMW_WR, bus_wdata 0x7799AABB, word address 0x040; sh to addr 0x100 with wdata 0x0000CDEF -> 0x8899CDEF.
- sw addr 0x104 wdata 0xDEADBEEF with ack delayed 3 cycles -> bus_req held 4 cycles with stable addr/data; done asserted 1 cycle after ack.
- lh addr 0x101 and lw addr 0x102 -> no bus_req; misalign=1 and done=1 on the 2nd cycle; rdata=0.
- TIMEOUT=16, ack never asserted on an sb -> bus_req drops after 16 cycles; bus_err=1 with done; no write cycle issued.
- Assert rst during RMW_WR with bus_req high -> bus_req, stall and done go to 0 asynchronously. After release: state IDLE, and a fresh lw completes normally.
